// File: rtl/acsi_sd_sequencer.sv
// Splits ACSI multi-sector requests into single-sector SD transactions interleaved with DMA buffer phases.
// Optional watchdog/abort enabled with `define ACSI_SD_TIMEOUT_EN.
module acsi_sd_sequencer #(
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd8000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  rd_req,
    input  logic [1:0]  wr_req,
    input  logic [31:0] lba,
    input  logic [15:0] length,
    output logic        data_busy,
    output logic        data_done,
    output logic        data_next,
    output logic        dma_done,
    output logic [1:0]  sd_rd,
    output logic [1:0]  sd_wr,
    output logic [31:0] sd_lba,
    input  logic        sd_busy,
    input  logic        sd_done,
    output logic        dma_start,
    input  logic        dma_sector_done,
    output logic        error
);
    typedef enum logic [3:0] {
        S_IDLE, S_ZERO, S_RD_ISSUE, S_RD_WAIT, S_DMA_WAIT,
        S_WR_DMA, S_WR_ISSUE, S_WR_WAIT, S_STEP
    } state_t;

    state_t      state_q, state_d;
    logic        tgt_q, tgt_d, dir_q, dir_d, iss_q, iss_d;
    logic [31:0] lba_q, lba_d;
    logic [15:0] rem_q, rem_d;
    logic        data_busy_q, data_busy_d, data_done_q, data_done_d;
    logic        data_next_q, data_next_d, dma_done_q, dma_done_d;
    logic        dma_start_q, dma_start_d;
    logic        sd_fin;

    // sd_done with sd_busy in ISSUE completes the sector just like sd_done in WAIT
    assign sd_fin = sd_done &&
        (state_q == S_RD_WAIT || state_q == S_WR_WAIT ||
         ((state_q == S_RD_ISSUE || state_q == S_WR_ISSUE) && sd_busy));

`ifdef ACSI_SD_TIMEOUT_EN
    logic [23:0] wd_q, wd_d;
    logic        error_q, error_d;
    logic        watch;

    assign watch = state_q inside {S_RD_ISSUE, S_RD_WAIT, S_DMA_WAIT,
                                   S_WR_DMA, S_WR_ISSUE, S_WR_WAIT};
`endif

    always_comb begin
        state_d     = state_q;
        tgt_d       = tgt_q;
        dir_d       = dir_q;
        iss_d       = iss_q;
        lba_d       = lba_q;
        rem_d       = rem_q;
        data_busy_d = 1'b0;
        data_done_d = 1'b0;
        data_next_d = 1'b0;
        dma_done_d  = 1'b0;
        dma_start_d = 1'b0;
`ifdef ACSI_SD_TIMEOUT_EN
        error_d     = error_q;
        wd_d        = '0;
`endif
        case (state_q)
            S_IDLE: if ((|rd_req) || (|wr_req)) begin
                data_busy_d = 1'b1;
                dir_d       = ~|rd_req;
                tgt_d       = (|rd_req) ? ~rd_req[0] : ~wr_req[0];
                lba_d       = lba;
                rem_d       = length;
`ifdef ACSI_SD_TIMEOUT_EN
                error_d     = 1'b0;
`endif
                if (length == 16'd0) begin
                    state_d = S_ZERO;
                end else if (~|rd_req) begin
                    state_d     = S_WR_DMA;
                    dma_start_d = 1'b1;
                end else begin
                    state_d = S_RD_ISSUE;
                    iss_d   = 1'b1;
                end
            end
            S_ZERO: begin
                dma_done_d = 1'b1;
                state_d    = S_IDLE;
            end
            S_RD_ISSUE, S_WR_ISSUE: if (sd_busy) begin
                iss_d   = 1'b0;
                state_d = dir_q ? S_WR_WAIT : S_RD_WAIT;
            end
            S_DMA_WAIT: if (dma_sector_done) state_d = S_STEP;
            S_WR_DMA: if (dma_sector_done) begin
                state_d = S_WR_ISSUE;
                iss_d   = 1'b1;
            end
            S_STEP: begin
                if (rem_q == 16'd1) dma_done_d  = 1'b1;
                else                data_next_d = 1'b1;
                state_d = S_IDLE;
            end
            default: ;
        endcase
        if (sd_fin) begin
            data_done_d = 1'b1;
            if (dir_q) begin
                state_d = S_STEP;
            end else begin
                dma_start_d = 1'b1;
                state_d     = S_DMA_WAIT;
            end
        end
`ifdef ACSI_SD_TIMEOUT_EN
        if (watch && state_d == state_q) wd_d = wd_q + 24'd1;
        // abort wins over any completion arriving in the same cycle
        if (watch && wd_q == TIMEOUT_CYCLES - 24'd1) begin
            state_d     = S_IDLE;
            iss_d       = 1'b0;
            data_done_d = 1'b0;
            dma_start_d = 1'b0;
            error_d     = 1'b1;
            dma_done_d  = 1'b1;
            wd_d        = '0;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            tgt_q       <= 1'b0;
            dir_q       <= 1'b0;
            iss_q       <= 1'b0;
            lba_q       <= '0;
            rem_q       <= '0;
            data_busy_q <= 1'b0;
            data_done_q <= 1'b0;
            data_next_q <= 1'b0;
            dma_done_q  <= 1'b0;
            dma_start_q <= 1'b0;
`ifdef ACSI_SD_TIMEOUT_EN
            error_q     <= 1'b0;
            wd_q        <= '0;
`endif
        end else begin
            state_q     <= state_d;
            tgt_q       <= tgt_d;
            dir_q       <= dir_d;
            iss_q       <= iss_d;
            lba_q       <= lba_d;
            rem_q       <= rem_d;
            data_busy_q <= data_busy_d;
            data_done_q <= data_done_d;
            data_next_q <= data_next_d;
            dma_done_q  <= dma_done_d;
            dma_start_q <= dma_start_d;
`ifdef ACSI_SD_TIMEOUT_EN
            error_q     <= error_d;
            wd_q        <= wd_d;
`endif
        end
    end

    assign sd_rd     = (iss_q && !dir_q) ? {tgt_q, ~tgt_q} : 2'b00;
    assign sd_wr     = (iss_q &&  dir_q) ? {tgt_q, ~tgt_q} : 2'b00;
    assign sd_lba    = lba_q;
    assign data_busy = data_busy_q;
    assign data_done = data_done_q;
    assign data_next = data_next_q;
    assign dma_done  = dma_done_q;
    assign dma_start = dma_start_q;

`ifdef ACSI_SD_TIMEOUT_EN
    assign error = error_q;
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
    assign error = 1'b0;
`endif
endmodule

// File: doc/acsi_sd_sequencer.md
Name: acsi_sd_sequencer

Overview:
- Sits between the ACSI controller and the SD-card sector engine.
- Accepts per-target read/write requests (lba, sector count) from the ACSI block and splits them into single-sector SD transactions.
- Interleaves each SD transaction with the DMA buffer phase.
- Returns the busy/done/next/dma_done handshake pulses the ACSI block consumes to step LBA and raise its IRQ.

Parameters:
- TIMEOUT_CYCLES, 24'd8000000, watchdog limit per sector phase. Used only with ACSI_SD_TIMEOUT_EN.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- rd_req  in  2  per-target read request from ACSI (bit = target 0/1); level, held until busy
- wr_req  in  2  per-target write request from ACSI; level, held until busy
- lba  in  32  starting sector of the request
- length  in  16  remaining sectors of the request
- data_busy  out  1  1-cycle pulse: request accepted (ACSI clears rd_req/wr_req)
- data_done  out  1  1-cycle pulse: SD sector phase finished
- data_next  out  1  1-cycle pulse: ACSI must re-request with lba+1, length-1
- dma_done  out  1  1-cycle pulse: whole transfer finished
- sd_rd  out  2  SD read strobe per target; level until sd_busy
- sd_wr  out  2  SD write strobe per target; level until sd_busy
- sd_lba  out  32  sector address to SD engine
- sd_busy  in  1  SD engine accepted strobe
- sd_done  in  1  1-cycle pulse: SD sector complete
- dma_start  out  1  1-cycle pulse: DMA may move the 512-byte buffer
- dma_sector_done  in  1  1-cycle pulse: DMA moved 512 bytes
- error  out  1  sticky abort flag, cleared on next accepted request

Behaviour:
- Reset: state IDLE. Every output is 0; sd_lba = 0. Internal tgt, dir, remaining are all cleared.
- Request selection in IDLE:
  - Priority is rd_req[0] > rd_req[1] > wr_req[0] > wr_req[1].
  - Latch tgt, dir, sd_lba <= lba, remaining <= length, clear error.
  - Pulse data_busy in the same cycle the request is latched (request sampled cycle N, data_busy high cycle N+1).
- Zero length: length == 0 at accept -> pulse dma_done the cycle after data_busy, return to IDLE, no SD access.
- Read path: IDLE -> RD_ISSUE -> RD_WAIT -> DMA_WAIT -> STEP.
  - RD_ISSUE: sd_rd[tgt] = 1 until a cycle with sd_busy = 1, deasserted the following cycle.
  - RD_WAIT: on sd_done, pulse data_done and dma_start, go to DMA_WAIT.
- Write path: IDLE -> WR_DMA -> WR_ISSUE -> WR_WAIT -> STEP.
  - WR_DMA: pulse dma_start on entry, wait for dma_sector_done.
  - WR_ISSUE: sd_wr[tgt] handshake identical to RD_ISSUE.
  - WR_WAIT: on sd_done, pulse data_done, go to STEP.
- DMA_WAIT: on dma_sector_done go to STEP.
- STEP:
  - remaining == 1 -> pulse dma_done, go to IDLE.
  - Otherwise -> pulse data_next, go to IDLE. ACSI re-asserts the request with lba+1 and length-1; the sequencer does not count internally beyond the current request.
- Pulse rules:
  - data_busy, data_done, data_next, dma_done, dma_start are each exactly 1 cycle.
  - At most one of data_next/dma_done is high per cycle.
  - Never more than one bit of sd_rd|sd_wr is high.
- Simultaneous events:
  - sd_done arriving in the same cycle as sd_busy is honoured: skip WAIT, proceed as if sd_done arrived in WAIT.
  - Stray sd_done or dma_sector_done in IDLE is ignored.
- Requests arriving while not IDLE are held off. No data_busy is issued, and the request is serviced after return to IDLE.
- Reset mid-operation: immediate return to IDLE with all strobes low. No dma_done is emitted.

Optional Feature:
- Macro: ACSI_SD_TIMEOUT_EN.
- With the macro:
  - A 24-bit watchdog clears on every state change and counts in RD_WAIT, WR_WAIT, DMA_WAIT, WR_DMA and both ISSUE states.
  - At count == TIMEOUT_CYCLES-1: drop strobes, set error = 1, pulse dma_done, go to IDLE.
- Without the macro: no counter, error is tied to 0, and states wait indefinitely.

Test Plan:
- Read, 1 sector: rd_req=2'b01, lba=100, length=1; sd_busy 2 cycles after sd_rd; sd_done 10 cycles later; dma_sector_done 5 cycles later. Expected: data_busy once, sd_lba=100, sd_rd=2'b01 deasserted after sd_busy, data_done+dma_start same cycle, dma_done once, no data_next.
- Read, 3 sectors on target 1, bench models ACSI re-request (lba 7,8,9; length 3,2,1). Expected: sd_lba sequence 7,8,9; data_next twice; dma_done once after third dma_sector_done.
- Write, 2 sectors on target 0: dma_start precedes sd_wr each sector; sd_wr=2'b01 only after dma_sector_done; data_next then dma_done.
- Priority and zero length:
  - rd_req=2'b10 and wr_req=2'b01 same cycle -> target-1 read serviced first, write serviced after return to IDLE.
  - length=0 -> dma_done 1 cycle after data_busy, sd strobes never asserted.
- Reset asserted while in RD_WAIT -> next cycle all outputs 0, state IDLE; a later request is processed normally.
- With ACSI_SD_TIMEOUT_EN, TIMEOUT_CYCLES=16, sd_done withheld -> error=1 and dma_done pulse exactly 16 cycles after entering RD_WAIT; the next accepted request clears error.
